axis_stream_checker: RTL

Self-checking AXI4-Stream receive-side test device for the NoC stream bench. It terminates an `axi_stream_interface.slave` port and applies optional pseudo-random backpressure. It checks every accepted packet against the incrementing-pattern stream produced by the team's stream traffic generators, and reports packet, drop and error counts plus a pass/done verdict to the testbench.

---
 rtl/axis_stream_checker_if.sv | 22 ++
 rtl/axis_stream_checker.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/axis_stream_checker_if.sv
// AXI4-Stream bundle shared by stream generators and checkers.
interface axi_stream_interface;
   logic        tvalid;
   logic        tready;
   logic [63:0] tdata;
   logic [7:0]  tstrb;
   logic [7:0]  tkeep;
   logic        tlast;
   logic [7:0]  tid;
   logic [7:0]  tdest;
   logic [7:0]  tuser;

   modport master (
      output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
      input  tready
   );

   modport slave (
      input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
      output tready
   );
endinterface

// File: rtl/axis_stream_checker.sv
// AXI4-Stream receive-side checker: terminates a stream, optionally applies
// LFSR backpressure, and checks packets against an incrementing pattern.
module axis_stream_checker #(
   parameter logic [7:0]  ACCEPT_ID = 8'd0,
   parameter logic [7:0]  EXP_DEST  = 8'd0,
   parameter int unsigned LEN       = 24,
   parameter logic [63:0] BASE      = 64'hdeadbeef00000000,
   parameter int unsigned NUM_PKTS  = 4,
   parameter bit          STALL_EN  = 1'b0,
   parameter logic [15:0] LFSR_SEED = 16'hace1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   axi_stream_interface.slave axis,
   input  logic               clear_i,
   output logic               done_o,
   output logic               pass_o,
   output logic [15:0]        pkt_cnt_o,
   output logic [15:0]        drop_cnt_o,
   output logic [15:0]        err_cnt_o,
   output logic [4:0]         first_err_code_o,
   output logic [7:0]         first_err_beat_o,
   output logic [63:0]        first_err_data_o
);

   localparam logic [7:0]  LAST_IDX   = 8'(LEN - 1);
   localparam logic [15:0] NUM_PKTS_W = 16'(NUM_PKTS);

   typedef enum logic {IDLE, RECV} state_t;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hffff) ? v : v + 16'd1;
   endfunction

   state_t      state_q;
   logic [7:0]  idx_q;
   logic [15:0] lfsr_q, lfsr_d;
   logic        tready_q;
   logic [15:0] pkt_q, pkt_d, drop_q, drop_d, err_q, err_d;
   logic        done_q, done_d, pass_q, pass_d;
   logic        have_err_q, have_err_d;
   logic [4:0]  fcode_q, fcode_d;
   logic [7:0]  fbeat_q, fbeat_d;
   logic [63:0] fdata_q, fdata_d;

   logic        acc_w, sel_w, chk_w, drop_w, err_any_w;
   logic [4:0]  code_w;
   logic [63:0] exp_data_w;

   // clear wins over a same-cycle handshake: the beat is consumed but ignored
   assign acc_w  = axis.tvalid & tready_q;
   assign sel_w  = (axis.tid == ACCEPT_ID);
   assign chk_w  = acc_w & sel_w & ~clear_i;
   assign drop_w = acc_w & ~sel_w & ~clear_i;

   assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

   // per-beat error bits against the expected pattern at the current index
   always_comb begin
      exp_data_w = BASE + {56'd0, idx_q};
      code_w     = '0;
      code_w[0]  = (axis.tdata != exp_data_w);
      code_w[1]  = (axis.tstrb != 8'hff) || (axis.tkeep != 8'hff);
      code_w[2]  = axis.tlast && (idx_q < LAST_IDX);
      code_w[3]  = !axis.tlast && (idx_q >= LAST_IDX);
      code_w[4]  = (axis.tdest != EXP_DEST);
      err_any_w  = |code_w;
   end

   // backpressure: free-running LFSR, tready registered from its low bits
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lfsr_q   <= LFSR_SEED;
         tready_q <= 1'b0;
      end else begin
         lfsr_q   <= lfsr_d;
         tready_q <= STALL_EN ? (lfsr_q[0] | lfsr_q[1]) : 1'b1;
      end
   end

   // packet framing FSM and beat index
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         idx_q   <= 8'd0;
      end else if (clear_i) begin
         state_q <= IDLE;
         idx_q   <= 8'd0;
      end else if (chk_w) begin
         if (axis.tlast) begin
            state_q <= IDLE;
            idx_q   <= 8'd0;
         end else begin
            state_q <= RECV;
            // in IDLE the accepted beat is beat 0, so the next one is beat 1
            if (state_q == IDLE)       idx_q <= 8'd1;
            else if (idx_q != 8'hff)   idx_q <= idx_q + 8'd1;
         end
      end
   end

   // next-state for counters, verdict and first-error capture
   always_comb begin
      pkt_d      = pkt_q;
      drop_d     = drop_q;
      err_d      = err_q;
      have_err_d = have_err_q;
      fcode_d    = fcode_q;
      fbeat_d    = fbeat_q;
      fdata_d    = fdata_q;
      if (clear_i) begin
         pkt_d      = '0;
         drop_d     = '0;
         err_d      = '0;
         have_err_d = 1'b0;
         fcode_d    = '0;
         fbeat_d    = '0;
         fdata_d    = '0;
      end else begin
         if (drop_w) drop_d = sat_inc(drop_q);
         if (chk_w) begin
            if (axis.tlast) pkt_d = sat_inc(pkt_q);
            if (err_any_w) begin
               err_d = sat_inc(err_q);
               if (!have_err_q) begin
                  have_err_d = 1'b1;
                  fcode_d    = code_w;
                  fbeat_d    = idx_q;
                  fdata_d    = axis.tdata;
               end
            end
         end
      end
      done_d = (pkt_d >= NUM_PKTS_W);
      pass_d = done_d && (err_d == 16'd0);
   end

   // counter, verdict and capture registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pkt_q      <= '0;
         drop_q     <= '0;
         err_q      <= '0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         have_err_q <= 1'b0;
         fcode_q    <= '0;
         fbeat_q    <= '0;
         fdata_q    <= '0;
      end else begin
         pkt_q      <= pkt_d;
         drop_q     <= drop_d;
         err_q      <= err_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         have_err_q <= have_err_d;
         fcode_q    <= fcode_d;
         fbeat_q    <= fbeat_d;
         fdata_q    <= fdata_d;
      end
   end

   assign axis.tready      = tready_q;
   assign done_o           = done_q;
   assign pass_o           = pass_q;
   assign pkt_cnt_o        = pkt_q;
   assign drop_cnt_o       = drop_q;
   assign err_cnt_o        = err_q;
   assign first_err_code_o = fcode_q;
   assign first_err_beat_o = fbeat_q;
   assign first_err_data_o = fdata_q;

endmodule
